// File: rtl/seq_gen_traffic_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_gen_traffic_ctrl                                             |
// | Brief   : Sequencer driving an address and a data random_seq_gen through  |
// |           fixed-length bursts with idle gaps over a valid/ready interface. |
// |           Optional stall counter under SEQ_GEN_TRAFFIC_CTRL_STATS_EN.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module seq_gen_traffic_ctrl #(
   parameter int unsigned NUM_XACT_WIDTH  = 16,
   parameter int unsigned BURST_LEN_WIDTH = 8,
   parameter int unsigned IDLE_GAP_WIDTH  = 4
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_go,
   input  logic                       i_stop,
   input  logic [NUM_XACT_WIDTH-1:0]  i_num_xact,
   input  logic [BURST_LEN_WIDTH-1:0] i_burst_len,
   input  logic [IDLE_GAP_WIDTH-1:0]  i_idle_gap,
   input  logic                       i_ready,
   output logic                       o_gen_start,
   output logic                       o_addr_enable,
   output logic                       o_data_enable,
   output logic                       o_valid,
   output logic                       o_last,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [NUM_XACT_WIDTH-1:0]  o_xact_count,
   output logic [31:0]                o_stall_cycles
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_SEND = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                     r_state;
   logic                       r_go_d;
   logic [NUM_XACT_WIDTH-1:0]  r_num_xact;
   logic [BURST_LEN_WIDTH-1:0] r_burst_len;
   logic [IDLE_GAP_WIDTH-1:0]  r_idle_gap;
   logic [BURST_LEN_WIDTH-1:0] r_beat_cnt;
   logic [IDLE_GAP_WIDTH-1:0]  r_gap_cnt;
   logic [NUM_XACT_WIDTH-1:0]  r_xact_count;
   logic                       r_stop_pending;
   logic                       r_gen_start;
   logic                       r_valid;
   logic                       r_busy;
   logic                       r_done;

   logic                       w_hs;
   logic                       w_last;
   logic [NUM_XACT_WIDTH-1:0]  w_count_inc;
   logic                       w_final;

   assign w_hs        = r_valid & i_ready;
   assign w_last      = (r_beat_cnt == r_burst_len);
   assign w_count_inc = r_xact_count + NUM_XACT_WIDTH'(1);
   assign w_final     = (r_num_xact != '0) && (w_count_inc == r_num_xact);

   // Generator enables follow the handshake directly so their outputs
   // advance on the same edge that consumes the beat.
   assign o_data_enable = w_hs;
   assign o_addr_enable = w_hs & w_last;
   assign o_valid       = r_valid;
   assign o_last        = r_valid & w_last;
   assign o_gen_start   = r_gen_start;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_xact_count  = r_xact_count;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state        <= S_IDLE;
         // Track i_go through reset so a level held across reset is not an edge.
         r_go_d         <= i_go;
         r_num_xact     <= '0;
         r_burst_len    <= '0;
         r_idle_gap     <= '0;
         r_beat_cnt     <= '0;
         r_gap_cnt      <= '0;
         r_xact_count   <= '0;
         r_stop_pending <= 1'b0;
         r_gen_start    <= 1'b0;
         r_valid        <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_go_d      <= i_go;
         r_gen_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_go && !r_go_d) begin
                  r_num_xact  <= i_num_xact;
                  r_burst_len <= i_burst_len;
                  r_idle_gap  <= i_idle_gap;
                  r_gen_start <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= S_INIT;
               end
            end
            S_INIT: begin
               r_xact_count   <= '0;
               r_beat_cnt     <= '0;
               r_stop_pending <= 1'b0;
               r_valid        <= 1'b1;
               r_state        <= S_SEND;
            end
            S_SEND: begin
               if (i_stop) begin
                  r_stop_pending <= 1'b1;
               end
               if (w_hs) begin
                  if (w_last) begin
                     r_beat_cnt <= '0;
                     if (r_xact_count != '1) begin
                        r_xact_count <= w_count_inc;
                     end
                     if (w_final || r_stop_pending || i_stop) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end else if (r_idle_gap != '0) begin
                        r_valid   <= 1'b0;
                        r_gap_cnt <= r_idle_gap;
                        r_state   <= S_GAP;
                     end
                  end else begin
                     r_beat_cnt <= r_beat_cnt + BURST_LEN_WIDTH'(1);
                  end
               end
            end
            S_GAP: begin
               if (i_stop) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_gap_cnt == IDLE_GAP_WIDTH'(1)) begin
                  r_valid <= 1'b1;
                  r_state <= S_SEND;
               end else begin
                  r_gap_cnt <= r_gap_cnt - IDLE_GAP_WIDTH'(1);
               end
            end
            S_DONE: begin
               if (!i_go) begin
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SEQ_GEN_TRAFFIC_CTRL_STATS_EN
   logic [31:0] r_stall_cycles;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_stall_cycles <= '0;
      end else if (r_state == S_INIT) begin
         r_stall_cycles <= '0;
      end else if (r_valid && !i_ready && (r_stall_cycles != '1)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign o_stall_cycles = r_stall_cycles;
`else
   assign o_stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_gen_traffic_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_seq_gen_traffic_ctrl                                          |
// | Brief   : Directed self-checking bench for seq_gen_traffic_ctrl.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_seq_gen_traffic_ctrl;

`ifdef SEQ_GEN_TRAFFIC_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk;
   logic        i_reset_n;
   logic        i_go;
   logic        i_stop;
   logic [15:0] i_num_xact;
   logic [7:0]  i_burst_len;
   logic [3:0]  i_idle_gap;
   logic        i_ready;
   logic        o_gen_start;
   logic        o_addr_enable;
   logic        o_data_enable;
   logic        o_valid;
   logic        o_last;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_xact_count;
   logic [31:0] o_stall_cycles;

   seq_gen_traffic_ctrl #(
      .NUM_XACT_WIDTH (16),
      .BURST_LEN_WIDTH(8),
      .IDLE_GAP_WIDTH (4)
   ) dut (
      .i_clk         (clk),
      .i_reset_n     (i_reset_n),
      .i_go          (i_go),
      .i_stop        (i_stop),
      .i_num_xact    (i_num_xact),
      .i_burst_len   (i_burst_len),
      .i_idle_gap    (i_idle_gap),
      .i_ready       (i_ready),
      .o_gen_start   (o_gen_start),
      .o_addr_enable (o_addr_enable),
      .o_data_enable (o_data_enable),
      .o_valid       (o_valid),
      .o_last        (o_last),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_xact_count  (o_xact_count),
      .o_stall_cycles(o_stall_cycles)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          errors;
   int          checks;
   int          cyc_n, nv, v1, v2, vlast;
   int          n_start, n_dat, n_addr, n_stall, n_viol;
   int          cnt_first;
   logic [63:0] last_mask;
   logic        p_valid, p_hs;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      cyc_n = 0; nv = 0; v1 = -1; v2 = -1; vlast = -1;
      n_start = 0; n_dat = 0; n_addr = 0; n_stall = 0; n_viol = 0;
      cnt_first = -1; last_mask = '0; p_valid = 1'b0; p_hs = 1'b0;
   endtask

   // Samples what the coming edge will act on, then advances one cycle.
   task automatic cyc();
      #1;
      if (o_gen_start) n_start++;
      if (o_valid) begin
         if (nv == 0) begin v1 = cyc_n; cnt_first = int'(o_xact_count); end
         if (nv == 1) v2 = cyc_n;
         nv++;
         if (o_last) last_mask = last_mask | (64'd1 << (nv - 1));
         vlast = cyc_n;
      end
      if (o_valid && !i_ready) n_stall++;
      if (o_data_enable) n_dat++;
      if (o_addr_enable) n_addr++;
      if (o_data_enable !== (o_valid & i_ready)) n_viol++;
      if (o_addr_enable !== (o_valid & i_ready & o_last)) n_viol++;
      if (p_valid && !p_hs && !o_valid) n_viol++;
      p_valid = o_valid;
      p_hs    = o_valid & i_ready;
      cyc_n++;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int maxc, input bit tog, input int stop_at);
      for (int k = 0; k < maxc; k++) begin
         if (o_done) break;
         if (tog) i_ready = k[0];
         i_stop = (stop_at >= 0) && (nv == stop_at) && o_valid;
         cyc();
      end
      i_stop = 1'b0;
   endtask

   initial begin
      errors = 0; checks = 0;
      i_reset_n = 1'b0; i_go = 1'b0; i_stop = 1'b0; i_ready = 1'b1;
      i_num_xact = 16'd0; i_burst_len = 8'd0; i_idle_gap = 4'd0;
      @(posedge clk); #1;
      cyc(); cyc();
      i_reset_n = 1'b1;
      clr();
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_busy",  o_busy, 0);
      chk("rst_done",  o_done, 0);
      chk("rst_start", o_gen_start, 0);
      chk("rst_count", o_xact_count, 0);
      chk("rst_stall", o_stall_cycles, 0);

      // Three 4-beat transactions back to back
      i_num_xact = 16'd3; i_burst_len = 8'd3; i_idle_gap = 4'd0; i_ready = 1'b1;
      i_go = 1'b1;
      run(40, 1'b0, -1);
      chk("t1_done",     o_done, 1);
      chk("t1_start",    n_start, 1);
      chk("t1_beats",    nv, 12);
      chk("t1_contig",   vlast - v1 + 1, 12);
      chk("t1_lastpos",  last_mask, 64'h888);
      chk("t1_data_en",  n_dat, 12);
      chk("t1_addr_en",  n_addr, 3);
      chk("t1_done_lat", cyc_n, vlast + 1);
      chk("t1_count",    o_xact_count, 3);
      chk("t1_stall",    o_stall_cycles, 0);
      chk("t1_viol",     n_viol, 0);

      // go held high keeps DONE
      cyc(); cyc(); cyc();
      chk("hold_done",  o_done, 1);
      chk("hold_busy",  o_busy, 1);
      chk("hold_start", n_start, 1);
      i_go = 1'b0;
      cyc();
      chk("idle_done",  o_done, 0);
      chk("idle_busy",  o_busy, 0);
      chk("idle_count", o_xact_count, 3);

      // Two single beats with a 5-cycle gap; config changes after go ignored
      clr();
      i_num_xact = 16'd2; i_burst_len = 8'd0; i_idle_gap = 4'd5;
      i_go = 1'b1;
      cyc();
      i_num_xact = 16'd9; i_burst_len = 8'd2; i_idle_gap = 4'd1;
      run(40, 1'b0, -1);
      chk("t2_done",    o_done, 1);
      chk("t2_start",   n_start, 1);
      chk("t2_beats",   nv, 2);
      chk("t2_gap",     v2 - v1 - 1, 5);
      chk("t2_cnt0",    cnt_first, 0);
      chk("t2_addr_en", n_addr, 2);
      chk("t2_count",   o_xact_count, 2);
      i_go = 1'b0;
      cyc();

      // Ready toggling with 2-beat bursts
      clr();
      i_num_xact = 16'd2; i_burst_len = 8'd1; i_idle_gap = 4'd0;
      i_go = 1'b1;
      run(40, 1'b1, -1);
      chk("t3_done",    o_done, 1);
      chk("t3_data_en", n_dat, 4);
      chk("t3_addr_en", n_addr, 2);
      chk("t3_viol",    n_viol, 0);
      chk("t3_nstall",  n_stall, 4);
      chk("t3_stall",   o_stall_cycles, STATS ? 64'd4 : 64'd0);
      chk("t3_count",   o_xact_count, 2);
      i_go = 1'b0; i_ready = 1'b1;
      cyc();

      // Continuous mode, stop during beat 2 of transaction 2
      clr();
      i_num_xact = 16'd0; i_burst_len = 8'd3; i_idle_gap = 4'd0;
      i_go = 1'b1;
      run(60, 1'b0, 5);
      chk("t4_done",  o_done, 1);
      chk("t4_beats", nv, 8);
      chk("t4_addr",  n_addr, 2);
      chk("t4_viol",  n_viol, 0);
      chk("t4_count", o_xact_count, 2);
      i_go = 1'b0;
      cyc();

      // Reset mid-burst in the second transaction
      clr();
      i_go = 1'b1;
      for (int k = 0; k < 30 && nv < 6; k++) cyc();
      chk("t5_pre_count", o_xact_count, 1);
      i_reset_n = 1'b0;
      cyc();
      i_reset_n = 1'b1;
      clr();
      chk("t5_valid", o_valid, 0);
      chk("t5_busy",  o_busy, 0);
      chk("t5_count", o_xact_count, 0);
      chk("t5_stall", o_stall_cycles, 0);
      cyc(); cyc(); cyc();
      chk("t5_norestart", n_start, 0);
      chk("t5_idle",      o_busy, 0);
      i_go = 1'b0;
      cyc();
      i_num_xact = 16'd1; i_burst_len = 8'd0;
      i_go = 1'b1;
      run(20, 1'b0, -1);
      chk("t5_restart", n_start, 1);
      chk("t5_rcount",  o_xact_count, 1);
      i_go = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
